// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing control for the 5-stage pipeline: load-use stalls, branch squashes,
// memory-wait freeze with timeout, and saturating activity counters.
module pipeline_hazard_controller #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ID_RegisterRs,
  input  logic [3:0]       ID_RegisterRt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             EX_MR,
  input  logic [3:0]       EX_RegisterRd,
  input  logic             EX_BranchTaken,
  input  logic             MEM_MR,
  input  logic             MEM_MW,
  input  logic             dmem_ready,
  input  logic             counter_clear,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             PipeEnable,
  output logic             dmem_req,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] freeze_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEMWAIT, ERROR} state_t;

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_error_q, mem_error_d;

  logic in_error, req, mem_stall, freeze, load_use, rs_hit, rt_hit;
  logic win_branch, win_stall;

  assign in_error  = (state_q == ERROR);
  assign req       = (MEM_MR | MEM_MW) & ~in_error & ~reset;
  assign mem_stall = req & ~dmem_ready;
  assign freeze    = mem_stall | in_error;

  assign rs_hit   = ID_UsesRs & (ID_RegisterRs == EX_RegisterRd);
  assign rt_hit   = ID_UsesRt & (ID_RegisterRt == EX_RegisterRd);
  assign load_use = EX_MR & (EX_RegisterRd != 4'd0) & (rs_hit | rt_hit);

  // A branch seen during a freeze is simply held in EX and wins once the freeze lifts.
  assign win_branch = ~freeze & EX_BranchTaken;
  assign win_stall  = ~freeze & ~EX_BranchTaken & load_use;

  assign PCWrite    = ~reset & ~freeze & ~win_stall;
  assign IFIDWrite  = ~reset & ~freeze & ~win_stall;
  assign IFIDFlush  = ~reset & win_branch;
  assign IDEXBubble = ~reset & (win_branch | win_stall);
  assign PipeEnable = ~reset & ~freeze;
  assign dmem_req   = req;
  assign mem_error  = mem_error_q;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEMWAIT;
          wait_cnt_d = 16'd1;
        end
      end
      MEMWAIT: begin
        if (dmem_ready || !req) begin
          state_d    = RUN;
          wait_cnt_d = 16'd0;
        end else if (wait_cnt_q == 16'(TIMEOUT_CYCLES)) begin
          state_d     = ERROR;
          mem_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= 16'd0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Counter slots: 0 = load-use stalls, 1 = freeze cycles, 2 = branch flushes.
  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  assign cnt_inc = {win_branch, freeze, win_stall};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (counter_clear) begin
          cnt_d[gi] = '0;
        end else if (cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
          cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end
    end
  endgenerate

  assign stall_cycles  = cnt_q[0];
  assign freeze_cycles = cnt_q[1];
  assign flush_count   = cnt_q[2];

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed scenarios plus randomized episodes compared against
// a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_controller;

  localparam int T    = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    ID_RegisterRs, ID_RegisterRt, EX_RegisterRd;
  logic          ID_UsesRs, ID_UsesRt, EX_MR, EX_BranchTaken;
  logic          MEM_MR, MEM_MW, dmem_ready, counter_clear;
  logic          PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeEnable, dmem_req, mem_error;
  logic [CW-1:0] stall_cycles, freeze_cycles, flush_count;

  pipeline_hazard_controller #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .ID_RegisterRs(ID_RegisterRs), .ID_RegisterRt(ID_RegisterRt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .EX_MR(EX_MR), .EX_RegisterRd(EX_RegisterRd), .EX_BranchTaken(EX_BranchTaken),
    .MEM_MR(MEM_MR), .MEM_MW(MEM_MW), .dmem_ready(dmem_ready), .counter_clear(counter_clear),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXBubble(IDEXBubble), .PipeEnable(PipeEnable), .dmem_req(dmem_req),
    .mem_error(mem_error), .stall_cycles(stall_cycles),
    .freeze_cycles(freeze_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: sticky error, length of the current unbroken wait, counters (stall, freeze, flush).
  bit m_err;
  int m_run;
  int m_cnt [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_err = 1'b0;
    m_run = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  task automatic set_idle();
    ID_RegisterRs = 4'd0; ID_RegisterRt = 4'd0; EX_RegisterRd = 4'd0;
    ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; EX_MR = 1'b0; EX_BranchTaken = 1'b0;
    MEM_MR = 1'b0; MEM_MW = 1'b0; dmem_ready = 1'b1; counter_clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"}, PCWrite, 0);
    check({tag, "_ifw"}, IFIDWrite, 0);
    check({tag, "_flush"}, IFIDFlush, 0);
    check({tag, "_bub"}, IDEXBubble, 0);
    check({tag, "_pe"}, PipeEnable, 0);
    check({tag, "_req"}, dmem_req, 0);
    check({tag, "_err"}, mem_error, 0);
    check({tag, "_stall"}, stall_cycles, 0);
    check({tag, "_frz"}, freeze_cycles, 0);
    check({tag, "_flc"}, flush_count, 0);
  endtask

  // Entered at posedge+1 with inputs already set; checks at posedge+4, returns at next posedge+1.
  task automatic run_cycle();
    bit req, frz, lu;
    bit [4:0] e;  // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeEnable}
    #3;
    req = (MEM_MR || MEM_MW) && !m_err;
    frz = (req && !dmem_ready) || m_err;
    lu  = EX_MR && (EX_RegisterRd != 0) &&
          ((ID_UsesRs && ID_RegisterRs == EX_RegisterRd) ||
           (ID_UsesRt && ID_RegisterRt == EX_RegisterRd));
    if (frz)                 e = 5'b00000;
    else if (EX_BranchTaken) e = 5'b11111;
    else if (lu)             e = 5'b00011;
    else                     e = 5'b11001;
    check("pc_write", PCWrite, e[4]);
    check("ifid_write", IFIDWrite, e[3]);
    check("ifid_flush", IFIDFlush, e[2]);
    check("idex_bubble", IDEXBubble, e[1]);
    check("pipe_enable", PipeEnable, e[0]);
    check("dmem_req", dmem_req, req);
    check("mem_error", mem_error, m_err);
    check("stall_cycles", stall_cycles, m_cnt[0]);
    check("freeze_cycles", freeze_cycles, m_cnt[1]);
    check("flush_count", flush_count, m_cnt[2]);
    if (counter_clear) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else if (frz) begin
      if (m_cnt[1] < CMAX) m_cnt[1]++;
    end else if (EX_BranchTaken) begin
      if (m_cnt[2] < CMAX) m_cnt[2]++;
    end else if (lu) begin
      if (m_cnt[0] < CMAX) m_cnt[0]++;
    end
    if (!m_err) begin
      if (req && !dmem_ready) begin
        m_run++;
        if (m_run > T) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1; reset rises between edges while inputs would otherwise drive outputs.
  task automatic async_reset(input string tag);
    MEM_MR = 1'b1; dmem_ready = 1'b0; EX_BranchTaken = 1'b1;
    #1 reset = 1'b1;
    #1 check_all_zero({tag, "_async"});
    @(posedge clk);
    #2 check_all_zero({tag, "_held"});
    reset = 1'b0;
    model_reset();
    set_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic stall_inputs();
    set_idle();
    EX_MR = 1'b1; EX_RegisterRd = 4'd5; ID_RegisterRs = 4'd5; ID_UsesRs = 1'b1;
  endtask

  task automatic clear_counters();
    set_idle();
    counter_clear = 1'b1;
    run_cycle();
    counter_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    model_reset();
    #3 check_all_zero("reset");
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // Load-use stall lasts one cycle, then the load has moved on.
    clear_counters();
    stall_inputs();
    run_cycle();
    check("lu_stall_count", stall_cycles, 1);
    EX_MR = 1'b0;
    run_cycle();
    stall_inputs();
    EX_RegisterRd = 4'd0; ID_RegisterRs = 4'd0;
    run_cycle();
    check("lu_r0_no_stall", stall_cycles, 1);

    // Branch together with load-use: branch wins.
    stall_inputs();
    EX_BranchTaken = 1'b1;
    run_cycle();
    check("br_flush_count", flush_count, 1);
    check("br_stall_unchanged", stall_cycles, 1);

    // Three-cycle memory wait.
    clear_counters();
    MEM_MR = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle();
    dmem_ready = 1'b1;
    run_cycle();
    check("memwait_freeze_cnt", freeze_cycles, 3);
    check("memwait_resume_pe", PipeEnable, 1);
    set_idle();
    run_cycle();

    // Timeout into sticky error, then reset.
    set_idle();
    MEM_MW = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < T + 3; i++) run_cycle();
    check("timeout_error", mem_error, 1);
    dmem_ready = 1'b1;
    for (int i = 0; i < 2; i++) run_cycle();
    check("error_sticky", mem_error, 1);
    check("error_frozen_pe", PipeEnable, 0);
    async_reset("err");

    // Counter saturation and clear.
    stall_inputs();
    for (int i = 0; i < 20; i++) run_cycle();
    check("stall_saturated", stall_cycles, CMAX);
    counter_clear = 1'b1;
    run_cycle();
    check("clear_pulse", stall_cycles, 0);
    run_cycle();
    check("clear_with_stall", stall_cycles, 0);
    counter_clear = 1'b0;

    // Reset mid-MEMWAIT.
    set_idle();
    MEM_MR = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) run_cycle();
    async_reset("memwait");
    stall_inputs();
    run_cycle();

    // Randomized episodes with varying memory latency behaviour.
    for (int ep = 0; ep < 16; ep++) begin
      int p_ready;
      p_ready = $urandom_range(40, 100);
      for (int c = 0; c < 150; c++) begin
        ID_RegisterRs  = 4'($urandom_range(0, 3));
        ID_RegisterRt  = 4'($urandom_range(0, 3));
        EX_RegisterRd  = 4'($urandom_range(0, 3));
        ID_UsesRs      = 1'($urandom_range(0, 1));
        ID_UsesRt      = 1'($urandom_range(0, 1));
        EX_MR          = 1'($urandom_range(0, 1));
        EX_BranchTaken = ($urandom_range(0, 99) < 20);
        MEM_MR         = ($urandom_range(0, 99) < 30);
        MEM_MW         = ($urandom_range(0, 99) < 20);
        dmem_ready     = ($urandom_range(0, 99) < p_ready);
        counter_clear  = ($urandom_range(0, 99) < 2);
        run_cycle();
      end
      async_reset("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
